// File: rtl/alu_mp_seq.sv
// Multi-precision add/sub sequencer: one WORDS*N-bit op driven through a shared N-bit alu, LSB word first.
// Latency WORDS clocks accept-to-rsp_valid; response held until rsp_ready. Optional ALU_SEQ_BACK2BACK_EN.
// Backpressure: req_ready only when idle (or retiring in DONE with ALU_SEQ_BACK2BACK_EN).
`ifndef ALU_ADD
`define ALU_ADD 6'd0
`endif

module alu_mp_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic                 req_cin,
  input  logic [N*WORDS-1:0]   req_a,
  input  logic [N*WORDS-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N*WORDS-1:0]   rsp_out,
  output logic                 rsp_cout,
  output logic                 rsp_overflow,
  output logic                 rsp_sign,
  output logic                 rsp_zero,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [5:0]           alu_op,
  output logic                 alu_cin,
  input  logic [N-1:0]         alu_out,
  input  logic                 alu_cout,
  input  logic                 alu_zero
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic            zacc_q, zacc_d;
  logic [W-1:0]    out_q, out_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            sign_q, sign_d;
  logic            zero_q, zero_d;
  logic            is_sub;

  assign is_sub    = (req_op == 2'd1);
  assign alu_op    = `ALU_ADD;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_out      = out_q;
  assign rsp_cout     = cout_q;
  assign rsp_overflow = ovf_q;
  assign rsp_sign     = sign_q;
  assign rsp_zero     = zero_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    zacc_d    = zacc_q;
    out_d     = out_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    sign_d    = sign_q;
    zero_d    = zero_q;
    req_ready = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;

    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_RUN: begin
        alu_a   = a_q[idx_q*N +: N];
        alu_b   = b_q[idx_q*N +: N];
        alu_cin = carry_q;
        out_d[idx_q*N +: N] = alu_out;
        carry_d = alu_cout;
        zacc_d  = zacc_q & alu_zero;
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = alu_cout;
          zero_d  = zacc_q & alu_zero;
          sign_d  = alu_out[N-1];
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (alu_out[N-1] != a_q[W-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
`ifdef ALU_SEQ_BACK2BACK_EN
        req_ready = rsp_ready;
`endif
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new request overrides the DONE->IDLE retire when back-to-back is enabled.
    if (req_valid && req_ready) begin
      a_d     = req_a;
      b_d     = is_sub ? ~req_b : req_b;
      carry_d = is_sub ? ~req_cin : req_cin;
      zacc_d  = 1'b1;
      idx_d   = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Directed bench for alu_mp_seq (N=8, WORDS=4) with a behavioural 8-bit adder as the alu.
`ifndef ALU_ADD
`define ALU_ADD 6'd0
`endif

module tb_alu_mp_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic        req_cin = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_out;
  logic        rsp_cout, rsp_overflow, rsp_sign, rsp_zero;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [5:0]  alu_op;
  logic        alu_cin, alu_cout, alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
  assign alu_zero = (alu_out == 8'd0);

  alu_mp_seq #(.N(8), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cin(req_cin),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_cout(rsp_cout),
    .rsp_overflow(rsp_overflow), .rsp_sign(rsp_sign), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero)
  );

  // Issue one op, wait for the response, leave it pending (rsp_ready=0). lat = edges after accept.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic [31:0] e_out,
                         input logic e_cout, input logic e_ovf, input logic e_sign, input logic e_zero);
    int lat;
    start_op(op, a, b, cin, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL %s latency got %0d want 4", name, lat); end
    checks++;
    if ({rsp_out, rsp_cout, rsp_overflow, rsp_sign, rsp_zero} !== {e_out, e_cout, e_ovf, e_sign, e_zero}) begin
      errors++;
      $display("FAIL %s result got out=%h c=%b v=%b s=%b z=%b want out=%h c=%b v=%b s=%b z=%b", name,
               rsp_out, rsp_cout, rsp_overflow, rsp_sign, rsp_zero, e_out, e_cout, e_ovf, e_sign, e_zero);
    end
    retire();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_out !== e_out) begin
      errors++;
      $display("FAIL %s retire got valid=%b ready=%b out=%h want 0 1 %h", name, rsp_valid, req_ready, rsp_out, e_out);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, rsp_valid, rsp_out, rsp_cout, rsp_overflow, rsp_sign, rsp_zero} !== {2'b10, 36'd0}) begin
      errors++;
      $display("FAIL reset got ready=%b valid=%b out=%h flags=%b%b%b%b want 1 0 0 0000", req_ready, rsp_valid,
               rsp_out, rsp_cout, rsp_overflow, rsp_sign, rsp_zero);
    end
    checks++;
    if ({alu_a, alu_b, alu_cin} !== 17'd0 || alu_op !== `ALU_ADD) begin
      errors++;
      $display("FAIL reset_alu got a=%h b=%h cin=%b op=%h want 0 0 0 %h", alu_a, alu_b, alu_cin, alu_op, `ALU_ADD);
    end
  endtask

  task automatic test_stall;
    int lat;
    logic [31:0] held;
    int bad = 0;
    start_op(2'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    held = 32'h2345_6789;
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'hAAAA_AAAA; req_b = 32'h5555_5555;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_out !== held || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall got %0d bad cycles (valid=%b out=%h ready=%b) want 0", bad, rsp_valid, rsp_out, req_ready);
    end
    @(negedge clk); req_valid = 1'b0;
    retire();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_out !== held) begin
      errors++;
      $display("FAIL stall_retire got valid=%b out=%h want 0 %h", rsp_valid, rsp_out, held);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'h0101_0101; req_b = 32'h0202_0202; req_cin = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (alu_a !== 8'h01 || alu_b !== 8'h02) begin
      errors++;
      $display("FAIL mid_run_word2 got a=%h b=%h want 01 02", alu_a, alu_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_out !== 32'd0 || alu_a !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_run got valid=%b out=%h alu_a=%h want 0 0 0", rsp_valid, rsp_out, alu_a);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_back_to_back;
    int cyc = 0, t1 = -1, t2 = -1, want;
    logic [31:0] out1 = '0, out2 = '0;
`ifdef ALU_SEQ_BACK2BACK_EN
    want = 5;
`else
    want = 6;
`endif
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b1; req_op = 2'd0; req_cin = 1'b0;
    req_a = 32'h1111_1111; req_b = 32'h2222_2222;
    @(posedge clk); #1;
    req_a = 32'h0000_0001; req_b = 32'h0000_0002;
    while (t2 < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin
        if (t1 < 0) begin t1 = cyc; out1 = rsp_out; end
        else if (cyc > t1) begin t2 = cyc; out2 = rsp_out; end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (t1 < 0 || t2 < 0 || (t2 - t1) !== want) begin
      errors++;
      $display("FAIL b2b_spacing got t1=%0d t2=%0d gap=%0d want gap %0d", t1, t2, t2 - t1, want);
    end
    checks++;
    if (out1 !== 32'h3333_3333 || out2 !== 32'h0000_0003) begin
      errors++;
      $display("FAIL b2b_results got %h %h want 33333333 00000003", out1, out2);
    end
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_op("add_ff_1",   2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    test_op("add_wrap",   2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    test_op("add_ovf",    2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    test_op("add_rsv_ci", 2'd2, 32'h0000_0010, 32'h0000_0020, 1'b1, 32'h0000_0031, 1'b0, 1'b0, 1'b0, 1'b0);
    test_op("sub_1_2",    2'd1, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    test_op("sub_5_5",    2'd1, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    test_op("sub_ovf",    2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    test_op("sub_borrow", 2'd1, 32'h0000_0005, 32'h0000_0002, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
